// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one 32-bit logarithmic left shifter between two requesters and
//   performs SLL / SRL / SRA. Right shifts reuse the left shifter by bit
//   reversing the operand and the result; SRA ORs in a sign-fill mask.
//   Each requester owns one slot flag (at most one transaction in flight per
//   requester) and one registered response with back-pressure.
// Ports
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_reqK_valid / o_reqK_ready          request handshake, K = 0,1
//   i_reqK_data[31:0], i_reqK_shamt[4:0], i_reqK_op[1:0]
//                                        operand, amount, op (00 SLL, 01 SRL,
//                                        10 SRA, 11 treated as SLL)
//   o_rspK_valid / i_rspK_ready          response handshake
//   o_rspK_data[31:0]                    result
//   o_busy                               either slot occupied
// Parameter
//   RR_EN  1 = round robin, 0 = req0 always has priority

module shifter_left (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data
);
  logic [31:0] w_st0, w_st1, w_st2, w_st3;

  assign w_st0  = i_shamt[0] ? {i_data[30:0], 1'b0}  : i_data;
  assign w_st1  = i_shamt[1] ? {w_st0[29:0], 2'b0}   : w_st0;
  assign w_st2  = i_shamt[2] ? {w_st1[27:0], 4'b0}   : w_st1;
  assign w_st3  = i_shamt[3] ? {w_st2[23:0], 8'b0}   : w_st2;
  assign o_data = i_shamt[4] ? {w_st3[15:0], 16'b0}  : w_st3;
endmodule

module shift_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_data,
  input  logic [4:0]  i_req0_shamt,
  input  logic [1:0]  i_req0_op,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_data,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_data,
  input  logic [4:0]  i_req1_shamt,
  input  logic [1:0]  i_req1_op,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_data,
  output logic        o_busy
);
  logic        r_busy0, r_busy1;
  logic        r_last_grant;
  logic        r_s1_valid, r_s1_id;
  logic [1:0]  r_s1_op;
  logic [31:0] r_s1_data;
  logic [4:0]  r_s1_shamt;
  logic        r_rsp0_valid, r_rsp1_valid;
  logic [31:0] r_rsp0_data, r_rsp1_data;

  logic        w_elig0, w_elig1, w_prio0;
  logic        w_hs0, w_hs1, w_rsp_hs0, w_rsp_hs1;
  logic        w_right, w_sra;
  logic [31:0] w_shift_in, w_shift_out, w_shift_adj, w_fill_mask, w_result;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bitrev[i] = v[31-i];
  endfunction

  // Arbitration: ready never looks at the requester's own valid.
  // r_last_grant = 1 means req1 won last, so req0 holds priority.
  assign w_elig0 = i_req0_valid & ~r_busy0;
  assign w_elig1 = i_req1_valid & ~r_busy1;
  assign w_prio0 = RR_EN ? r_last_grant : 1'b1;

  assign o_req0_ready = i_rst_n & ~r_busy0 & (~w_elig1 | w_prio0);
  assign o_req1_ready = i_rst_n & ~r_busy1 & (~w_elig0 | ~w_prio0);

  assign w_hs0     = i_req0_valid & o_req0_ready;
  assign w_hs1     = i_req1_valid & o_req1_ready;
  assign w_rsp_hs0 = r_rsp0_valid & i_rsp0_ready;
  assign w_rsp_hs1 = r_rsp1_valid & i_rsp1_ready;

  // Compute from S1
  assign w_right    = (r_s1_op == 2'b01) | (r_s1_op == 2'b10);
  assign w_sra      = (r_s1_op == 2'b10);
  assign w_shift_in = w_right ? bitrev(r_s1_data) : r_s1_data;

  shifter_left u_shifter (
    .i_data  (w_shift_in),
    .i_shamt (r_s1_shamt),
    .o_data  (w_shift_out)
  );

  assign w_shift_adj = w_right ? bitrev(w_shift_out) : w_shift_out;

  // Top shamt bits are sign-filled; empty when shamt is 0.
  always_comb begin
    w_fill_mask = '0;
    for (int i = 0; i < 32; i++) begin
      if ((r_s1_shamt != 5'd0) && (6'(i) >= (6'd32 - {1'b0, r_s1_shamt})))
        w_fill_mask[i] = 1'b1;
    end
  end

  assign w_result = w_shift_adj | ((w_sra & r_s1_data[31]) ? w_fill_mask : 32'h0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy0      <= 1'b0;
      r_busy1      <= 1'b0;
      r_last_grant <= 1'b1;
      r_s1_valid   <= 1'b0;
      r_s1_id      <= 1'b0;
      r_s1_op      <= 2'b00;
      r_s1_data    <= 32'h0;
      r_s1_shamt   <= 5'd0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= 32'h0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= 32'h0;
    end else begin
      // Slot flags: set and clear can never coincide for the same requester.
      if (w_hs0)          r_busy0 <= 1'b1;
      else if (w_rsp_hs0) r_busy0 <= 1'b0;
      if (w_hs1)          r_busy1 <= 1'b1;
      else if (w_rsp_hs1) r_busy1 <= 1'b0;

      if (w_hs0)      r_last_grant <= 1'b0;
      else if (w_hs1) r_last_grant <= 1'b1;

      // S1 needs no stall: the response slot is already reserved by busy.
      if (w_hs0) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= 1'b0;
        r_s1_op    <= i_req0_op;
        r_s1_data  <= i_req0_data;
        r_s1_shamt <= i_req0_shamt;
      end else if (w_hs1) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= 1'b1;
        r_s1_op    <= i_req1_op;
        r_s1_data  <= i_req1_data;
        r_s1_shamt <= i_req1_shamt;
      end else begin
        r_s1_valid <= 1'b0;
      end

      if (r_s1_valid && !r_s1_id) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_data  <= w_result;
      end else if (w_rsp_hs0) begin
        r_rsp0_valid <= 1'b0;
        r_rsp0_data  <= 32'h0;
      end

      if (r_s1_valid && r_s1_id) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= w_result;
      end else if (w_rsp_hs1) begin
        r_rsp1_valid <= 1'b0;
        r_rsp1_data  <= 32'h0;
      end
    end
  end

  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp0_data  = r_rsp0_data;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp1_data  = r_rsp1_data;
  assign o_busy       = r_busy0 | r_busy1;
endmodule
